// File: rtl/hazard_ctrl.sv
// hazard_ctrl: turns decoder hazard flags into stall and NOP-bubble controls
// for the IF/ID and ID/EX pipeline registers, with a bubble performance count.
module hazard_ctrl #(
    parameter int CTRL_BUBBLES = 2,
    parameter int CNT_W        = 4,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_id,
    input  logic              load_use_id,
    input  logic              ex_resolved,
    input  logic              mem_stall,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              id_bubble_en,
    output logic              ex_bubble_en,
    output logic [31:0]       bubble_instrn,
    output logic              busy,
    output logic              ctrl_timeout,
    output logic [PERF_W-1:0] bubble_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CT_WAIT  = 2'd1,
        LU_STALL = 2'd2
    } state_t;

    // cnt_q holds the bubbles still owed for the current jump/branch,
    // counting the CT_WAIT cycle in progress; 1 means this is the last one.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CTRL_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PERF_W-1:0] bcnt_q, bcnt_d;

    // ADDI x0,x0,0 loaded into IF/ID when a bubble is inserted
    assign bubble_instrn = 32'h0000_0013;
    assign busy          = !rst && (state_q != IDLE);
    assign bubble_count  = rst ? '0 : bcnt_q;

    // Next-state and output decode; reset blanks every control output
    always_comb begin
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        stall_ex     = 1'b0;
        id_bubble_en = 1'b0;
        ex_bubble_en = 1'b0;
        ctrl_timeout = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        if (!rst) begin
            if (mem_stall) begin
                // memory freeze dominates: hold everything, insert nothing
                stall_if = 1'b1;
                stall_id = 1'b1;
                stall_ex = 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (load_use_id) begin
                            stall_if     = 1'b1;
                            stall_id     = 1'b1;
                            ex_bubble_en = 1'b1;
                            state_d      = LU_STALL;
                        end else if (ctrl_id) begin
                            stall_if     = 1'b1;
                            id_bubble_en = 1'b1;
                            if (CTRL_BUBBLES > 1) begin
                                state_d = CT_WAIT;
                                cnt_d   = CNT_LOAD;
                            end
                        end
                    end
                    LU_STALL: begin
                        // the held instruction moves on; flags re-seen in IDLE
                        state_d = IDLE;
                    end
                    CT_WAIT: begin
                        stall_if     = 1'b1;
                        id_bubble_en = 1'b1;
                        if (ex_resolved) begin
                            state_d = IDLE;
                        end else if (cnt_q <= CNT_ONE) begin
                            state_d      = IDLE;
                            ctrl_timeout = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Bubble counter increments once per cycle with a bubble, wrapping naturally
    always_comb begin
        bcnt_d = bcnt_q;
        if (id_bubble_en || ex_bubble_en) begin
            bcnt_d = bcnt_q + PERF_W'(1);
        end
    end

    // State, wait counter and performance counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven check of hazard_ctrl plus directed sequences
// for a 3-bubble configuration and a 4-bit bubble counter wrap.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ctrl_id, load_use_id, ex_resolved, mem_stall;

    // instance A: CTRL_BUBBLES=2, PERF_W=32
    logic a_sif, a_sid, a_sex, a_idb, a_exb, a_busy, a_tmo;
    logic [31:0] a_instr, a_bc;
    // instance B: CTRL_BUBBLES=3
    logic b_sif, b_sid, b_sex, b_idb, b_exb, b_busy, b_tmo;
    logic [31:0] b_instr, b_bc;
    // instance C: CTRL_BUBBLES=2, PERF_W=4
    logic c_sif, c_sid, c_sex, c_idb, c_exb, c_busy, c_tmo;
    logic [31:0] c_instr;
    logic [3:0]  c_bc;

    hazard_ctrl #(.CTRL_BUBBLES(2), .CNT_W(4), .PERF_W(32)) dut_a (
        .clk(clk), .rst(rst), .ctrl_id(ctrl_id), .load_use_id(load_use_id),
        .ex_resolved(ex_resolved), .mem_stall(mem_stall),
        .stall_if(a_sif), .stall_id(a_sid), .stall_ex(a_sex),
        .id_bubble_en(a_idb), .ex_bubble_en(a_exb), .bubble_instrn(a_instr),
        .busy(a_busy), .ctrl_timeout(a_tmo), .bubble_count(a_bc));

    hazard_ctrl #(.CTRL_BUBBLES(3), .CNT_W(4), .PERF_W(32)) dut_b (
        .clk(clk), .rst(rst), .ctrl_id(ctrl_id), .load_use_id(load_use_id),
        .ex_resolved(ex_resolved), .mem_stall(mem_stall),
        .stall_if(b_sif), .stall_id(b_sid), .stall_ex(b_sex),
        .id_bubble_en(b_idb), .ex_bubble_en(b_exb), .bubble_instrn(b_instr),
        .busy(b_busy), .ctrl_timeout(b_tmo), .bubble_count(b_bc));

    hazard_ctrl #(.CTRL_BUBBLES(2), .CNT_W(4), .PERF_W(4)) dut_c (
        .clk(clk), .rst(rst), .ctrl_id(ctrl_id), .load_use_id(load_use_id),
        .ex_resolved(ex_resolved), .mem_stall(mem_stall),
        .stall_if(c_sif), .stall_id(c_sid), .stall_ex(c_sex),
        .id_bubble_en(c_idb), .ex_bubble_en(c_exb), .bubble_instrn(c_instr),
        .busy(c_busy), .ctrl_timeout(c_tmo), .bubble_count(c_bc));

    // packed view: {stall_if, stall_id, stall_ex, id_bub, ex_bub, busy, timeout}
    logic [6:0] a_o, b_o, c_o;
    assign a_o = {a_sif, a_sid, a_sex, a_idb, a_exb, a_busy, a_tmo};
    assign b_o = {b_sif, b_sid, b_sex, b_idb, b_exb, b_busy, b_tmo};
    assign c_o = {c_sif, c_sid, c_sex, c_idb, c_exb, c_busy, c_tmo};

    typedef struct packed {
        logic        rst;
        logic        ctrl;
        logic        lu;
        logic        exr;
        logic        ms;
        logic [6:0]  exp_o;
        logic [31:0] exp_bc;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void add(input logic r, input logic c, input logic l,
                                input logic e, input logic m,
                                input logic [6:0] o, input int bc);
        vq.push_back('{r, c, l, e, m, o, 32'(bc)});
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic l,
                         input logic e, input logic m);
        rst = r; ctrl_id = c; load_use_id = l; ex_resolved = e; mem_stall = m;
    endtask

    // advance to next cycle's drive point (1 time unit after rising edge)
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        //   rst ctrl lu exr ms   outputs      bubble_count
        add(1, 1, 1, 0, 0, 7'b0000000, 0);  // reset masks flags
        add(1, 0, 0, 0, 0, 7'b0000000, 0);
        add(0, 0, 0, 0, 0, 7'b0000000, 0);  // idle
        add(0, 1, 0, 0, 0, 7'b1001000, 0);  // branch: bubble 1
        add(0, 0, 0, 1, 0, 7'b1001010, 1);  // resolved early, bubble 2
        add(0, 0, 0, 0, 0, 7'b0000000, 2);
        add(0, 1, 0, 0, 0, 7'b1001000, 2);  // branch again
        add(0, 0, 0, 0, 0, 7'b1001011, 3);  // no resolve: timeout pulse
        add(0, 0, 0, 1, 0, 7'b0000000, 4);  // ex_resolved ignored in IDLE
        add(0, 1, 1, 0, 0, 7'b1100100, 4);  // load-use beats branch
        add(0, 1, 1, 0, 0, 7'b0000010, 5);  // LU_STALL: flags ignored
        add(0, 1, 0, 0, 0, 7'b1001000, 5);  // held branch now taken
        add(0, 0, 0, 1, 0, 7'b1001010, 6);
        add(0, 1, 0, 0, 0, 7'b1001000, 7);  // branch, then freeze in CT_WAIT
        add(0, 1, 0, 1, 1, 7'b1110010, 8);
        add(0, 1, 0, 1, 1, 7'b1110010, 8);
        add(0, 1, 0, 1, 1, 7'b1110010, 8);
        add(0, 0, 0, 0, 0, 7'b1001011, 8);  // resumes with same remaining count
        add(0, 0, 1, 0, 1, 7'b1110000, 9);  // freeze in IDLE blocks load-use
        add(0, 0, 1, 0, 0, 7'b1100100, 9);
        add(0, 0, 0, 0, 1, 7'b1110010, 10); // freeze holds LU_STALL
        add(0, 0, 0, 0, 0, 7'b0000010, 10);
        add(0, 1, 0, 0, 0, 7'b1001000, 10); // branch, then reset mid CT_WAIT
        add(1, 0, 0, 0, 0, 7'b0000000, 0);
        add(0, 0, 0, 0, 0, 7'b0000000, 0);
        add(0, 0, 0, 1, 0, 7'b0000000, 0);
        add(0, 1, 0, 0, 0, 7'b1001000, 0);  // counter reloaded after reset
        add(0, 0, 0, 0, 0, 7'b1001011, 1);
        add(0, 0, 0, 0, 0, 7'b0000000, 2);

        next_cycle();
        chk("bubble_instrn", 0, a_instr, 32'h0000_0013);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].ctrl, vq[i].lu, vq[i].exr, vq[i].ms);
            @(negedge clk);
            chk("vec_outputs", i, {25'd0, a_o}, {25'd0, vq[i].exp_o});
            chk("vec_bubble_count", i, a_bc, vq[i].exp_bc);
            if (a_idb && a_exb) chk("bubble_exclusive", i, 32'd1, 32'd0);
            next_cycle();
        end

        // CTRL_BUBBLES=3, never resolved: three bubbles, timeout on the third
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("cb3_c1_out", 1, {25'd0, b_o}, {25'd0, 7'b1001000});
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("cb3_c2_out", 2, {25'd0, b_o}, {25'd0, 7'b1001010});
        next_cycle();
        @(negedge clk);
        chk("cb3_c3_out", 3, {25'd0, b_o}, {25'd0, 7'b1001011});
        next_cycle();
        @(negedge clk);
        chk("cb3_c4_out", 4, {25'd0, b_o}, {25'd0, 7'b0000000});
        chk("cb3_count", 4, b_bc, 32'd3);

        // PERF_W=4: 17 load-use events wrap the counter 15 -> 0 -> 1
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        for (int k = 1; k <= 17; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            if (k == 1) chk("wrap_lu_out", k, {25'd0, c_o}, {25'd0, 7'b1100100});
            next_cycle();
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            if (k == 15 || k == 16 || k == 17)
                chk("wrap_count", k, {28'd0, c_bc}, 32'(k % 16));
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
